// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue with pre-decode; dual issue enabled by DECODE_QUEUE_PAIR_EN.
// Latency: an entry written at edge N is offered in cycle N+1; out_* is combinational from the head entries.
// Backpressure: in_ready needs two free slots (registered count only); the consumer pops via out_ready.
module decode_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  in_valid,
    input  logic [31:0] in_instr0,
    input  logic [31:0] in_instr1,
    input  logic [31:0] in_pc0,
    input  logic [31:0] in_pc1,
    output logic        in_ready,
    output logic [1:0]  out_valid,
    output logic [31:0] out_instr0,
    output logic [31:0] out_instr1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [2:0]  out_class0,
    output logic [2:0]  out_class1,
    output logic [4:0]  out_dst0,
    output logic [4:0]  out_dst1,
    output logic        out_bad0,
    output logic        out_bad1,
    input  logic        out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ROOM_LIM = (AW+1)'(DEPTH - 2);

    localparam logic [2:0] CLS_ALU  = 3'd0;
    localparam logic [2:0] CLS_MEM  = 3'd1;
    localparam logic [2:0] CLS_BRJ  = 3'd2;
    localparam logic [2:0] CLS_HILO = 3'd3;
    localparam logic [2:0] CLS_CP0  = 3'd4;
    localparam logic [2:0] CLS_EXC  = 3'd5;

    typedef struct packed {
        logic [2:0] cls;
        logic [4:0] dst;
        logic       bad;
    } dec_t;

    function automatic dec_t predecode(input logic [31:0] ins);
        dec_t d;
        d.cls = CLS_EXC;
        d.dst = 5'd0;
        d.bad = 1'b0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        d.cls = CLS_ALU;
                        d.dst = ins[15:11];
                    end
                    6'h08: d.cls = CLS_BRJ;
                    6'h09: begin
                        d.cls = CLS_BRJ;
                        d.dst = ins[15:11];
                    end
                    6'h0C, 6'h0D: d.cls = CLS_EXC;
                    6'h10, 6'h12: begin
                        d.cls = CLS_HILO;
                        d.dst = ins[15:11];
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: d.cls = CLS_HILO;
                    default: d.bad = 1'b1;
                endcase
            end
            6'h01: begin
                case (ins[20:16])
                    5'h00, 5'h01: d.cls = CLS_BRJ;
                    5'h10, 5'h11: begin
                        d.cls = CLS_BRJ;
                        d.dst = 5'd31;
                    end
                    default: d.bad = 1'b1;
                endcase
            end
            6'h02, 6'h04, 6'h05, 6'h06, 6'h07: d.cls = CLS_BRJ;
            6'h03: begin
                d.cls = CLS_BRJ;
                d.dst = 5'd31;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                d.cls = CLS_ALU;
                d.dst = ins[20:16];
            end
            6'h10: begin
                if (ins[25:21] == 5'h00) begin
                    d.cls = CLS_CP0;
                    d.dst = ins[20:16];
                end else if (ins[25:21] == 5'h04) begin
                    d.cls = CLS_CP0;
                end else if (ins[25] && ins[5:0] == 6'h18) begin
                    d.cls = CLS_CP0;
                end else begin
                    d.bad = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                d.cls = CLS_MEM;
                d.dst = ins[20:16];
            end
            6'h28, 6'h29, 6'h2B: d.cls = CLS_MEM;
            default: d.bad = 1'b1;
        endcase
        return d;
    endfunction

    logic [31:0]   instrMem [DEPTH];
    logic [31:0]   pcMem    [DEPTH];
    logic [AW:0]   wptr, rptr, count, pushCnt, popCnt;
    logic [AW-1:0] wIdx0, wIdx1, hIdx;
    logic          pushEn;
    dec_t          dec0;

    assign count    = wptr - rptr;
    assign in_ready = count <= ROOM_LIM;
    assign pushEn   = in_ready & in_valid[0] & ~flush;
    assign wIdx0    = wptr[AW-1:0];
    assign wIdx1    = wIdx0 + AW'(1);
    assign hIdx     = rptr[AW-1:0];

    always_comb begin
        pushCnt = '0;
        if (pushEn) pushCnt = in_valid[1] ? (AW+1)'(2) : (AW+1)'(1);
    end

    // Storage is intentionally unreset; out_valid qualifies everything read from it.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            instrMem[wIdx0] <= in_instr0;
            pcMem[wIdx0]    <= in_pc0;
            if (in_valid[1]) begin
                instrMem[wIdx1] <= in_instr1;
                pcMem[wIdx1]    <= in_pc1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            wptr <= wptr + pushCnt;
            rptr <= rptr + popCnt;
        end
    end

    assign out_instr0 = instrMem[hIdx];
    assign out_pc0    = pcMem[hIdx];
    assign dec0       = predecode(out_instr0);
    assign out_class0 = dec0.cls;
    assign out_dst0   = dec0.dst;
    assign out_bad0   = dec0.bad;
    assign out_valid[0] = count != '0;

`ifdef DECODE_QUEUE_PAIR_EN
    logic [AW-1:0] h1Idx;
    dec_t          dec1;
    logic          pairOk;

    assign h1Idx      = hIdx + AW'(1);
    assign out_instr1 = instrMem[h1Idx];
    assign out_pc1    = pcMem[h1Idx];
    assign dec1       = predecode(out_instr1);
    assign out_class1 = dec1.cls;
    assign out_dst1   = dec1.dst;
    assign out_bad1   = dec1.bad;

    // Second slot reads rs/rt of its own word; a RAW on either blocks the pair.
    assign pairOk = (count >= (AW+1)'(2))
                  && (dec0.cls == CLS_ALU || dec0.cls == CLS_MEM)
                  && (dec1.cls == CLS_ALU) && !dec1.bad
                  && (dec0.dst == 5'd0
                      || (dec0.dst != out_instr1[25:21] && dec0.dst != out_instr1[20:16]));
    assign out_valid[1] = pairOk;
`else
    assign out_instr1   = '0;
    assign out_pc1      = '0;
    assign out_class1   = '0;
    assign out_dst1     = '0;
    assign out_bad1     = 1'b0;
    assign out_valid[1] = 1'b0;
`endif

    always_comb begin
        popCnt = '0;
        if (out_ready && out_valid[0] && !flush)
            popCnt = out_valid[1] ? (AW+1)'(2) : (AW+1)'(1);
    end

    logic unusedCls;
    assign unusedCls = (CLS_BRJ == CLS_HILO) | (CLS_CP0 == CLS_EXC);
endmodule

// File: tb/tb_decode_queue.sv
// Directed scoreboard bench for decode_queue; expectations adapt to DECODE_QUEUE_PAIR_EN.
module tb_decode_queue;
    localparam int DEPTH = 8;
`ifdef DECODE_QUEUE_PAIR_EN
    localparam bit PAIR = 1'b1;
`else
    localparam bit PAIR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  cls;
        logic [4:0]  dst;
        logic        bad;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_valid = 2'b00;
    logic [31:0] in_instr0 = '0, in_instr1 = '0, in_pc0 = '0, in_pc1 = '0;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
    logic [2:0]  out_class0, out_class1;
    logic [4:0]  out_dst0, out_dst1;
    logic        out_bad0, out_bad1;

    ent_t sb[$];
    int   nAsserts = 0;
    int   nFail = 0;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_instr0(out_instr0), .out_instr1(out_instr1), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_class0(out_class0), .out_class1(out_class1), .out_dst0(out_dst0), .out_dst1(out_dst1),
        .out_bad0(out_bad0), .out_bad1(out_bad1), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] i, input logic [31:0] p,
                                input logic [2:0] c, input logic [4:0] d, input logic b);
        ent_t e;
        e.instr = i;
        e.pc    = p;
        e.cls   = c;
        e.dst   = d;
        e.bad   = b;
        return e;
    endfunction

    // Filler entries: BREAK or reserved opcode 0x3F, all class EXC so they never pair.
    function automatic ent_t fe(input int k);
        if (k % 3 == 0)
            return mk(32'h0000000D, 32'h1000 + 32'(k) * 4, 3'd5, 5'd0, 1'b0);
        return mk(32'hFC000000 | 32'(k), 32'h1000 + 32'(k) * 4, 3'd5, 5'd0, 1'b1);
    endfunction

    task automatic checkHead(input logic [1:0] expValid);
        check("out_valid", 32'(out_valid), 32'(expValid));
        if (expValid[0] && sb.size() > 0) begin
            check("instr0", out_instr0, sb[0].instr);
            check("pc0", out_pc0, sb[0].pc);
            check("class0", 32'(out_class0), 32'(sb[0].cls));
            check("dst0", 32'(out_dst0), 32'(sb[0].dst));
            check("bad0", 32'(out_bad0), 32'(sb[0].bad));
        end
        if (expValid[1] && sb.size() > 1) begin
            check("instr1", out_instr1, sb[1].instr);
            check("pc1", out_pc1, sb[1].pc);
            check("class1", 32'(out_class1), 32'(sb[1].cls));
            check("dst1", 32'(out_dst1), 32'(sb[1].dst));
            check("bad1", 32'(out_bad1), 32'(sb[1].bad));
        end
    endtask

    // One clock: check current offer, drive push/pop/flush, advance, update the scoreboard.
    task automatic cycle(input logic [1:0] vld, input ent_t a, input ent_t b,
                         input bit rdy, input logic [1:0] expValid, input bit fl);
        bit ready;
        ready = (DEPTH - sb.size()) >= 2;
        check("in_ready", 32'(in_ready), 32'(ready));
        checkHead(expValid);
        in_valid  = vld;
        in_instr0 = a.instr;
        in_pc0    = a.pc;
        in_instr1 = b.instr;
        in_pc1    = b.pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
        in_valid  = 2'b00;
        out_ready = 1'b0;
        flush     = 1'b0;
        if (fl) begin
            sb.delete();
        end else begin
            if (rdy && expValid[0] && sb.size() > 0) begin
                void'(sb.pop_front());
                if (expValid[1] && sb.size() > 0) void'(sb.pop_front());
            end
            if (ready && vld[0]) begin
                sb.push_back(a);
                if (vld[1]) sb.push_back(b);
            end
        end
    endtask

    initial begin
        ent_t z;
        z = '0;
        #2 rst = 1'b0;
        #10;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // addu $3 + addiu $7: independent ALU pair
        cycle(2'b11, mk(32'h00221821, 32'h100, 3'd0, 5'd3, 1'b0),
                     mk(32'h24070001, 32'h104, 3'd0, 5'd7, 1'b0), 1'b0, 2'b00, 1'b0);
        cycle(2'b00, z, z, 1'b1, PAIR ? 2'b11 : 2'b01, 1'b0);
        cycle(2'b00, z, z, 1'b1, PAIR ? 2'b00 : 2'b01, 1'b0);
        cycle(2'b00, z, z, 1'b0, 2'b00, 1'b0);

        // addu $3 then or $5,$3,$4: RAW blocks the pair
        cycle(2'b11, mk(32'h00221821, 32'h200, 3'd0, 5'd3, 1'b0),
                     mk(32'h00642825, 32'h204, 3'd0, 5'd5, 1'b0), 1'b0, 2'b00, 1'b0);
        cycle(2'b00, z, z, 1'b1, 2'b01, 1'b0);
        cycle(2'b00, z, z, 1'b1, 2'b01, 1'b0);

        // lw $8 + syscall, illegal 2'b10 push, then a reserved opcode
        cycle(2'b11, mk(32'h8C280000, 32'h300, 3'd1, 5'd8, 1'b0),
                     mk(32'h0000000C, 32'h304, 3'd5, 5'd0, 1'b0), 1'b0, 2'b00, 1'b0);
        cycle(2'b00, z, z, 1'b1, 2'b01, 1'b0);
        cycle(2'b10, mk(32'h24070001, 32'h3F0, 3'd0, 5'd7, 1'b0), z, 1'b1, 2'b01, 1'b0);
        cycle(2'b01, mk(32'hFC000000, 32'h308, 3'd5, 5'd0, 1'b1), z, 1'b0, 2'b00, 1'b0);
        cycle(2'b00, z, z, 1'b1, 2'b01, 1'b0);
        cycle(2'b00, z, z, 1'b0, 2'b00, 1'b0);

        // Fill to full (first pair straddles index 7 -> 0), then push+pop across wrap
        for (int i = 0; i < 4; i++)
            cycle(2'b11, fe(2 * i), fe(2 * i + 1), 1'b0, sb.size() > 0 ? 2'b01 : 2'b00, 1'b0);
        for (int j = 0; j < 20; j++)
            cycle(2'b11, fe(8 + 2 * j), fe(9 + 2 * j), 1'b1, sb.size() > 0 ? 2'b01 : 2'b00, 1'b0);
        for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++)
            cycle(2'b00, z, z, 1'b1, 2'b01, 1'b0);
        cycle(2'b00, z, z, 1'b0, 2'b00, 1'b0);

        // Six entries, then flush with a simultaneous push that must be dropped
        for (int i = 0; i < 3; i++)
            cycle(2'b11, fe(100 + 2 * i), fe(101 + 2 * i), 1'b0, sb.size() > 0 ? 2'b01 : 2'b00, 1'b0);
        cycle(2'b11, mk(32'h00221821, 32'h600, 3'd0, 5'd3, 1'b0),
                     mk(32'h24070001, 32'h604, 3'd0, 5'd7, 1'b0), 1'b1, 2'b01, 1'b1);
        cycle(2'b00, z, z, 1'b0, 2'b00, 1'b0);
        cycle(2'b01, mk(32'h00221821, 32'h700, 3'd0, 5'd3, 1'b0), z, 1'b0, 2'b00, 1'b0);
        cycle(2'b00, z, z, 1'b1, 2'b01, 1'b0);
        cycle(2'b00, z, z, 1'b0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
